// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_buf_state_e;

    localparam int UART_DATA_W_DEF = 8;

endpackage

// File: rtl/uart_tx_buffer.sv
// TX byte queue feeding the shifter one word per frame; optional parity via UART_TX_PARITY_EN.
// Latency: push into an empty idle buffer -> tx_start two edges later; one idle cycle between frames.
// Backpressure: wr_ready = !full; writes while full are dropped and raise sticky overflow.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W_DEF,
    parameter int DEPTH  = 4
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    input  logic                       clr_ovf
`ifdef UART_TX_PARITY_EN
    ,
    output logic                       parity_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    tx_buf_state_e     state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = !full;
    assign tx_start = tx_start_q;
    assign data_out = data_out_q;
    assign count    = count_q;
    assign overflow = overflow_q;
`ifdef UART_TX_PARITY_EN
    assign parity_out = parity_q;
`endif

    always_comb begin
        // Push depends on full only, so a same-cycle pop never frees a slot early.
        push       = wr_valid && !full;
        pop        = (state_q == IDLE) && !empty && !tx_busy;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        tx_start_d = 1'b0;
        data_out_d = data_out_q;
        overflow_d = overflow_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (clr_ovf) begin
            overflow_d = 1'b0;
        end else if (wr_valid && full) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    data_out_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d   = (^mem_q[rd_ptr_q]) ^ PARITY_ODD;
`endif
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    tx_start_d = 1'b1;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            data_out_q <= data_out_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: queue-based reference model plus a counting shifter model.
module tb_uart_tx_buffer;

    localparam int DW       = 8;
    localparam int DEPTH    = 4;
    localparam int CW       = $clog2(DEPTH+1);
    localparam int BUSY_LEN = 10;
    localparam bit P_ODD    = 1'b0;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          tx_busy;
    logic          tx_start;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          clr_ovf;
`ifdef UART_TX_PARITY_EN
    logic          parity_out;
`endif

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .DATA_W(DW),
        .DEPTH (DEPTH)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD(P_ODD)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .data_out  (data_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef UART_TX_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: words waiting behind the current frame, sticky overflow, current frame word.
    logic [DW-1:0] m_q[$];
    logic          m_ovf;
    logic [DW-1:0] exp_data;
    int            m_pop_err;
    bit            auto_busy;
    int            busy_cnt;
    int            cyc;

    task automatic model_reset();
        m_q.delete();
        m_ovf     = 1'b0;
        exp_data  = '0;
        busy_cnt  = 0;
        tx_busy   = 1'b0;
        m_pop_err = 0;
    endtask

    // One clock: drive inputs, advance, then update the model from the spec's rules.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic c);
        int sz;
        wr_valid = v;
        wr_data  = d;
        clr_ovf  = c;
        sz = m_q.size();
        @(posedge clk);
        #1;
        if (tx_start) begin
            if (sz == 0) m_pop_err++;
            else exp_data = m_q.pop_front();
        end
        if (v && sz < DEPTH) m_q.push_back(d);
        if (c) m_ovf = 1'b0;
        else if (v && sz == DEPTH) m_ovf = 1'b1;
        cyc++;
        if (auto_busy) begin
            if (busy_cnt > 0) busy_cnt--;
            if (tx_start) busy_cnt = BUSY_LEN;
            tx_busy = (busy_cnt > 0);
        end
        wr_valid = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic drain(output bit timed_out);
        int n = 0;
        auto_busy = 1'b1;
        while ((m_q.size() != 0 || busy_cnt != 0) && n < 400) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        timed_out = (n >= 400);
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_valid = 1'b0; wr_data = '0; clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        reset = 1'b1;
    endtask

    task automatic test_midframe_reset();
        auto_busy = 1'b1;
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'h04, 1'b0);
        total++; if (count !== CW'(3) || tx_busy !== 1'b1) begin bad++; $display("FAIL mid_setup: got count=%0d busy=%b want 3/1", count, tx_busy); end
        #2 reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1 ||
                tx_start !== 1'b0 || data_out !== '0 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_outputs: got cnt=%0d e=%b f=%b rdy=%b st=%b d=%h ovf=%b want 0/1/0/1/0/00/0",
                         count, empty, full, wr_ready, tx_start, data_out, overflow);
            end
            @(posedge clk);
        end
        #1 reset = 1'b1;
        auto_busy = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, '0, 1'b0);
            total++; if (tx_start !== 1'b0 || count !== '0) begin bad++; $display("FAIL mid_no_start: got st=%b cnt=%0d want 0/0", tx_start, count); end
        end
    endtask

    task automatic test_single();
        bit to;
        auto_busy = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0);
        total++; if (tx_start !== 1'b0 || count !== CW'(1)) begin bad++; $display("FAIL single_push: got st=%b cnt=%0d want 0/1", tx_start, count); end
        cycle(1'b0, '0, 1'b0);
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_latency: got st=%b want 1", tx_start); end
        total++; if (data_out !== 8'hA5 || count !== '0) begin bad++; $display("FAIL single_data: got d=%h cnt=%0d want a5/0", data_out, count); end
        cycle(1'b0, '0, 1'b0);
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", tx_start); end
        drain(to);
        total++; if (to) begin bad++; $display("FAIL single_drain: got timeout want done"); end
    endtask

    task automatic test_fill_overflow();
        logic [DW-1:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        auto_busy = 1'b0;
        tx_busy   = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, words[i], 1'b0);
        total++; if (full !== 1'b1 || wr_ready !== 1'b0 || count !== CW'(DEPTH)) begin bad++; $display("FAIL fill_full: got f=%b rdy=%b cnt=%0d want 1/0/4", full, wr_ready, count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf: got %b want 0", overflow); end
        cycle(1'b1, 8'h55, 1'b0);
        total++; if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_set: got ovf=%b cnt=%0d want 1/4", overflow, count); end
        cycle(1'b0, '0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        cycle(1'b1, 8'h66, 1'b1);
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_clr_wins: got %b want %b", overflow, m_ovf); end
    endtask

    task automatic test_order();
        logic [DW-1:0] words [4];
        int frames = 0;
        int last_cyc = 0;
        int n = 0;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        tx_busy   = 1'b0;
        auto_busy = 1'b1;
        while (frames < 4 && n < 200) begin
            cycle(1'b0, '0, 1'b0);
            n++;
            if (tx_start) begin
                total++; if (data_out !== words[frames]) begin bad++; $display("FAIL order_data: got %h want %h", data_out, words[frames]); end
                if (frames > 0) begin
                    total++; if (cyc - last_cyc != BUSY_LEN + 2) begin bad++; $display("FAIL order_gap: got %0d want %0d", cyc - last_cyc, BUSY_LEN + 2); end
                end
                last_cyc = cyc;
                frames++;
            end else if (frames > 0) begin
                total++; if (data_out !== words[frames-1]) begin bad++; $display("FAIL order_stable: got %h want %h", data_out, words[frames-1]); end
            end
        end
        total++; if (frames != 4) begin bad++; $display("FAIL order_timeout: got %0d frames want 4", frames); end
        begin
            bit to;
            drain(to);
            total++; if (to || count !== '0 || empty !== 1'b1) begin bad++; $display("FAIL order_drain: got to=%b cnt=%0d e=%b want 0/0/1", to, count, empty); end
        end
    endtask

    task automatic test_same_cycle();
        bit to;
        auto_busy = 1'b0;
        tx_busy   = 1'b0;
        cycle(1'b1, 8'hC0, 1'b0);
        cycle(1'b1, 8'hC1, 1'b0);
        total++; if (tx_start !== 1'b1 || data_out !== 8'hC0) begin bad++; $display("FAIL same_first: got st=%b d=%h want 1/c0", tx_start, data_out); end
        tx_busy = 1'b1;
        cycle(1'b1, 8'hC2, 1'b0);
        tx_busy = 1'b0;
        total++; if (count !== CW'(2)) begin bad++; $display("FAIL same_setup: got %0d want 2", count); end
        cycle(1'b0, '0, 1'b0);
        auto_busy = 1'b1;
        cycle(1'b1, 8'hC3, 1'b0);
        total++; if (tx_start !== 1'b1 || data_out !== 8'hC1) begin bad++; $display("FAIL same_pop: got st=%b d=%h want 1/c1", tx_start, data_out); end
        total++; if (count !== CW'(2) || full !== 1'b0 || empty !== 1'b0) begin bad++; $display("FAIL same_count: got cnt=%0d f=%b e=%b want 2/0/0", count, full, empty); end
        drain(to);
        total++; if (to || m_pop_err != 0) begin bad++; $display("FAIL same_drain: got to=%b poperr=%0d want 0/0", to, m_pop_err); end
    endtask

    task automatic test_random();
        bit to;
        logic v, c;
        logic [DW-1:0] d;
        auto_busy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 99) < 40);
            c = ($urandom_range(0, 99) < 5);
            d = DW'($urandom);
            cycle(v, d, c);
            total++;
            if (count !== CW'(m_q.size()) || full !== (m_q.size() == DEPTH) ||
                empty !== (m_q.size() == 0) || wr_ready !== (m_q.size() != DEPTH)) begin
                bad++;
                $display("FAIL rand_level: got cnt=%0d f=%b e=%b rdy=%b want cnt=%0d", count, full, empty, wr_ready, m_q.size());
            end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_ovf: got %b want %b", overflow, m_ovf); end
            total++; if (data_out !== exp_data) begin bad++; $display("FAIL rand_data: got %h want %h", data_out, exp_data); end
`ifdef UART_TX_PARITY_EN
            total++; if (parity_out !== ((^exp_data) ^ P_ODD)) begin bad++; $display("FAIL rand_parity: got %b want %b", parity_out, (^exp_data) ^ P_ODD); end
`endif
        end
        drain(to);
        total++; if (to || m_pop_err != 0) begin bad++; $display("FAIL rand_drain: got to=%b poperr=%0d want 0/0", to, m_pop_err); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit to;
        auto_busy = 1'b1;
        cycle(1'b1, 8'h07, 1'b0);
        cycle(1'b0, '0, 1'b0);
        total++; if (parity_out !== (1'b1 ^ P_ODD)) begin bad++; $display("FAIL parity_07: got %b want %b", parity_out, 1'b1 ^ P_ODD); end
        drain(to);
    endtask
`endif

    initial begin
        cyc = 0;
        auto_busy = 1'b0;
        test_reset();
        test_midframe_reset();
        test_single();
        test_fill_overflow();
        test_order();
        test_same_cycle();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
